// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner
// Drives a HUB75 LED panel with binary-coded modulation. Each (row, plane) pair is
// shifted out of the frame memory while the previously latched pair is being shown.
// Plane p is shown for base_on<<p clocks. Blanking guard clocks surround every latch pulse.
// Constraints: rows, columns and depth are powers of two and at least 2. base_on >= 1 and blank >= 1.
module hub75_bcm_scanner #(
    parameter int rows    = 8,
    parameter int columns = 32,
    parameter int depth   = 8,
    parameter int base_on = 4,
    parameter int blank   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [$clog2(rows)-1:0]    rd_row,
    output logic [$clog2(columns)-1:0] rd_col,
    output logic [$clog2(depth)-1:0]   rd_plane,
    input  logic [6*depth-1:0]         pix,
    output logic                       r0,
    output logic                       g0,
    output logic                       b0,
    output logic                       r1,
    output logic                       g1,
    output logic                       b1,
    output logic [$clog2(rows)-1:0]    a,
    output logic                       oe,
    output logic                       lat,
    output logic                       oclk,
    output logic                       frame_start,
    output logic                       busy
);

    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns);
    localparam int PW = $clog2(depth);
    localparam int TW = $clog2(base_on) + depth;
    localparam int SW = $clog2(2 * columns + 2);
    localparam int BW = $clog2(blank + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PRIME      = 3'd1;
    localparam logic [2:0] RUN        = 3'd2;
    localparam logic [2:0] BLANK_PRE  = 3'd3;
    localparam logic [2:0] LATCH      = 3'd4;
    localparam logic [2:0] BLANK_POST = 3'd5;

    // The step counter runs from 0 to 2*columns+1.
    // An even step presents an address and an odd step captures its data.
    // The last step only drops oclk.
    localparam logic [SW-1:0] STEP_LAST      = SW'(2 * columns + 1);
    localparam logic [SW-1:0] STEP_LAST_ADDR = SW'(2 * columns - 1);
    localparam logic [BW-1:0] BLANK_LOAD     = BW'(blank - 1);
    localparam logic [RW-1:0] ROW_LAST       = RW'(rows - 1);
    localparam logic [PW-1:0] PLANE_LAST     = PW'(depth - 1);
    localparam logic [TW-1:0] BASE           = TW'(base_on);

    logic [2:0]    state;
    logic [SW-1:0] step;
    logic          shift_done;
    logic [TW-1:0] timer;
    logic [BW-1:0] blank_cnt;
    logic [5:0]    colour;
    logic [5:0]    plane_bits;
    logic          shifting;
    logic          handover;
    logic          post_done;
    logic          shift_start;
    logic          go_idle;

    // Pick the bit of the current plane out of each of the six colour channels.
    for (genvar k = 0; k < 6; k++) begin : g_chan
        logic [depth-1:0] chan;
        assign chan          = pix[k*depth +: depth];
        assign plane_bits[k] = chan[rd_plane];
    end

    assign {b1, g1, r1, b0, g0, r0} = colour;
    assign busy = (state != IDLE);

    // Decode the conditions under which the shift engine and the display engine hand over.
    always_comb begin
        shifting    = ((state == PRIME) || (state == RUN)) && !shift_done;
        handover    = ((state == PRIME) || (state == RUN)) && shift_done && (timer == '0);
        post_done   = (state == BLANK_POST) && (blank_cnt == '0);
        shift_start = ((state == IDLE) && en) || post_done;
        go_idle     = handover && !en;
    end

    // Control sequencer.
    // Walks through the blanking and latch phases.
    // Owns the panel row select and the (row, plane) pair being fetched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            blank_cnt   <= '0;
            lat         <= 1'b0;
            frame_start <= 1'b0;
            a           <= '0;
            rd_row      <= '0;
            rd_plane    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= PRIME;
                    end
                end
                PRIME, RUN: begin
                    if (handover) begin
                        if (en) begin
                            state     <= BLANK_PRE;
                            blank_cnt <= BLANK_LOAD;
                        end else begin
                            state    <= IDLE;
                            rd_row   <= '0;
                            rd_plane <= '0;
                        end
                    end
                end
                BLANK_PRE: begin
                    if (blank_cnt == '0) begin
                        state       <= LATCH;
                        lat         <= 1'b1;
                        a           <= rd_row;
                        frame_start <= (rd_row == '0) && (rd_plane == '0);
                    end else begin
                        blank_cnt <= blank_cnt - BW'(1);
                    end
                end
                LATCH: begin
                    state       <= BLANK_POST;
                    lat         <= 1'b0;
                    frame_start <= 1'b0;
                    blank_cnt   <= BLANK_LOAD;
                end
                BLANK_POST: begin
                    if (blank_cnt == '0) begin
                        state <= RUN;
                        if (rd_plane == PLANE_LAST) begin
                            rd_plane <= '0;
                            rd_row   <= (rd_row == ROW_LAST) ? '0 : rd_row + RW'(1);
                        end else begin
                            rd_plane <= rd_plane + PW'(1);
                        end
                    end else begin
                        blank_cnt <= blank_cnt - BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Shift engine.
    // Steps through the columns and captures each pixel one clock after its address.
    // oclk is raised in the clock that follows the data update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step       <= '0;
            shift_done <= 1'b0;
            rd_col     <= '0;
            oclk       <= 1'b0;
            colour     <= '0;
        end else if (shift_start) begin
            step       <= '0;
            shift_done <= 1'b0;
            rd_col     <= '0;
            oclk       <= 1'b0;
        end else if (go_idle) begin
            rd_col <= '0;
        end else if (shifting) begin
            step <= step + SW'(1);
            if (step[0]) begin
                oclk <= 1'b0;
                if (step == STEP_LAST) begin
                    shift_done <= 1'b1;
                end else begin
                    colour <= plane_bits;
                    if (step < STEP_LAST_ADDR) begin
                        rd_col <= rd_col + CW'(1);
                    end
                end
            end else if (step != '0) begin
                oclk <= 1'b1;
            end
        end
    end

    // Display engine.
    // Keeps oe low for base_on<<plane clocks after the latched plane goes live.
    // It is otherwise blanked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
            oe    <= 1'b1;
        end else if (post_done) begin
            timer <= BASE << rd_plane;
            oe    <= 1'b0;
        end else if ((state == RUN) && (timer != '0)) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) begin
                oe <= 1'b1;
            end
        end
    end

endmodule
